// File: rtl/uart_port_master_if.sv
// CPU-side port bus of the UART peripheral.
// Master drives strobes and write data; slave returns read data and interrupt.
interface uart_port_master_if;
  logic [7:0]  read;
  logic [7:0]  write;
  logic [15:0] out_port;
  logic [15:0] in_port;
  logic        interrupt;
  logic        interrupt_ack;

  modport master (
    output read,
    output write,
    output out_port,
    output interrupt_ack,
    input  in_port,
    input  interrupt
  );

  modport slave (
    input  read,
    input  write,
    input  out_port,
    input  interrupt_ack,
    output in_port,
    output interrupt
  );
endinterface

// File: rtl/uart_port_master.sv
// Hardware initiator for the UART port bus: TX FIFO in, RX bytes out,
// interrupt service, lost-interrupt polling and deferred config writes.
module uart_port_master #(
  parameter logic [7:0] CFG_DEFAULT = 8'hB8,
  parameter int         POLL_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cfg_in,
  input  logic       cfg_load,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [2:0] rx_err,
  uart_port_master_if.master port
);

  localparam int PW =
    (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST =
    PW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_ACK,
    S_STAT,
    S_RXR,
    S_TXW
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [7:0]    cfg_reg;
  logic          cfg_pending;
  logic          tx_idle;
  logic [2:0]    st_err;
  logic [PW-1:0] poll_cnt;

  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;
  logic       busy;
  logic       unused_in;

  assign tx_ready  = (count != 3'd4);
  assign push      = tx_valid & tx_ready;
  assign pop       = (state == S_IDLE) && (nxt == S_TXW);
  assign busy      = (count != 3'd0) && !tx_idle;
  assign unused_in = &{1'b0, port.in_port[15:8],
                       port.in_port[7:5]};

  always_comb begin
    nxt = S_IDLE;
    unique case (state)
      S_IDLE: begin
        if (cfg_pending && tx_idle)
          nxt = S_CFG;
        else if (port.interrupt)
          nxt = S_ACK;
        else if ((count != 3'd0) && tx_idle)
          nxt = S_TXW;
        else if (busy && (poll_cnt == POLL_LAST))
          nxt = S_STAT;
        else
          nxt = S_IDLE;
      end
      S_ACK:   nxt = S_STAT;
      S_STAT:  nxt = port.in_port[0] ? S_RXR : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Strobes are loaded on entry so each is high during its own state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      port.read          <= '0;
      port.write         <= '0;
      port.out_port      <= '0;
      port.interrupt_ack <= 1'b0;
      rx_data            <= '0;
      rx_err             <= '0;
      rx_valid           <= 1'b0;
      st_err             <= '0;
      tx_idle            <= 1'b1;
      cfg_pending        <= 1'b1;
      cfg_reg            <= CFG_DEFAULT;
      poll_cnt           <= '0;
    end else begin
      state              <= nxt;
      port.read          <= '0;
      port.write         <= '0;
      port.out_port      <= '0;
      port.interrupt_ack <= 1'b0;
      rx_valid           <= 1'b0;

      if (state == S_IDLE && nxt == S_IDLE && busy)
        poll_cnt <= (poll_cnt == POLL_LAST) ?
                    poll_cnt : poll_cnt + 1'b1;
      else
        poll_cnt <= '0;

      if (state == S_STAT) begin
        st_err  <= port.in_port[4:2];
        tx_idle <= port.in_port[1];
      end

      if (state == S_RXR) begin
        rx_data  <= port.in_port[7:0];
        rx_err   <= st_err;
        rx_valid <= 1'b1;
      end

      unique case (nxt)
        S_CFG: begin
          port.write    <= 8'h40;
          port.out_port <= {8'h00, cfg_reg};
          cfg_pending   <= 1'b0;
        end
        S_ACK:  port.interrupt_ack <= 1'b1;
        S_STAT: port.read <= 8'h02;
        S_RXR:  port.read <= 8'h01;
        S_TXW: begin
          port.write    <= 8'h01;
          port.out_port <= {8'h00, fifo_q[rd_ptr]};
          tx_idle       <= 1'b0;
        end
        default: ;
      endcase

      // A load in the same cycle as a config write re-arms it.
      if (cfg_load) begin
        cfg_reg     <= cfg_in;
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_port_master.md
Name: uart_port_master

Overview:
- Hardware initiator for the UART peripheral's CPU-side port interface. It replaces firmware as the driver of that interface.
- Drives the read, write, out_port and interrupt_ack strobes and consumes in_port and interrupt.
- Presents a simple valid/ready byte stream to fabric logic: a 4-entry TX FIFO in, RX bytes with error flags out.
- Also programs the UART configuration register (baud[7:4], eight[3], pen[2], ohel[1]).

Parameters:
- CFG_DEFAULT, 8'hB8, configuration byte written automatically after reset.
- POLL_CYCLES, 1024, number of idle cycles with TX stalled before a forced status read (lost-interrupt recovery).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_in  input  8  new configuration byte.
- cfg_load  input  1  one-cycle pulse; captures cfg_in for deferred write.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO not full; push when tx_valid & tx_ready.
- rx_data  output  8  last received byte; held until the next byte.
- rx_valid  output  1  one-cycle pulse, rx_data/rx_err new.
- rx_err  output  3  {ovf, ferr, perr} sampled with this byte.
- interrupt  input  1  UART interrupt (level, set by TxRdy/RxRdy rising edge).
- interrupt_ack  output  1  one-cycle interrupt clear.
- in_port  input  16  UART read data, combinational from read; sampled in the same cycle read is high.
- out_port  output  16  UART write data; upper byte always 0.
- read  output  8  read strobes: bit0 = RX data (clears RxRdy), bit1 = status. All other bits always 0.
- write  output  8  write strobes: bit0 = TX data load, bit6 = config. All other bits always 0.

Behaviour:
- Reset values:
  - read, write, out_port, interrupt_ack, rx_valid, rx_data, rx_err all 0.
  - tx_ready = 1; FIFO empty.
  - cfg_pending = 1 with cfg_reg = CFG_DEFAULT.
  - tx_idle shadow = 1; poll counter = 0; FSM enters CFG.
- Strobe timing:
  - FSM outputs are registered.
  - Each strobe is high for exactly one clk cycle per visit to its state.
  - out_port is stable during that same cycle.
- Status byte layout: [0] RxRdy, [1] TxRdy, [2] perr, [3] ferr, [4] ovf.
- States and transitions:
  - CFG: write = 8'h40, out_port = {8'h00, cfg_reg}. Clear cfg_pending. Go to IDLE.
  - IDLE: evaluated in strict priority order, one action per visit:
    1. cfg_pending & tx_idle -> CFG.
    2. interrupt -> ACK.
    3. FIFO non-empty & tx_idle -> TXW.
    4. FIFO non-empty & !tx_idle & poll counter == POLL_CYCLES-1 -> STAT.
    5. Otherwise remain in IDLE.
  - ACK: interrupt_ack = 1 -> STAT.
  - STAT: read = 8'h02. Latch in_port[7:0] as status; tx_idle <= status[1]. If status[0] -> RXR, else -> IDLE.
  - RXR: read = 8'h01. rx_data <= in_port[7:0]; rx_err <= status[4:2]. Pulse rx_valid on the following cycle. Go to IDLE.
  - TXW: write = 8'h01, out_port = {8'h00, FIFO head}. Pop the FIFO; tx_idle <= 0. Go to IDLE.
- Poll counter:
  - Increments each IDLE cycle while FIFO is non-empty and !tx_idle.
  - Clears on any exit from IDLE, and whenever that condition is false.
  - Saturates; never wraps.
- cfg_load:
  - Any cycle: cfg_reg <= cfg_in, cfg_pending <= 1.
  - A later cfg_load before the config write overwrites the earlier one (last wins).
  - The config write is deferred while a frame is in flight (tx_idle = 0).
- FIFO:
  - Depth 4, 3-bit count.
  - Push and pop in the same cycle leave the count unchanged.
  - Push is ignored when full (tx_ready = 0).
  - Pop happens only in TXW, which is never entered when the FIFO is empty.
- Simultaneous interrupt and pending TX in IDLE: the interrupt wins. The status read then refreshes tx_idle before any TX write.
- A reset assertion mid-operation immediately forces all reset values. A partially written strobe cycle is abandoned.

Test Plan:
- Release reset -> cycle 1 after release: write = 8'h40, out_port = 16'h00B8 for one cycle; then idle with all strobes 0.
- Push 8'h55 with tx_idle = 1 -> one write = 8'h01 cycle with out_port = 16'h0055; tx_ready stays 1. No second write until interrupt, then status read returning 8'h02.
- Raise interrupt; in_port = 8'h01 on the status read and 8'hA7 on the data read -> observed sequence: interrupt_ack, read = 02, read = 01, then rx_valid pulse with rx_data = A7, rx_err = 0.
- Status read returns 8'h13 (RxRdy, TxRdy, ovf) -> rx_err = 3'b100 with the byte; tx_idle set, so a queued TX byte is written next.
- Push 5 bytes while tx_idle = 0 -> tx_ready drops after 4. Withhold interrupt -> forced status read exactly POLL_CYCLES idle cycles later.
- cfg_load 8'h3C twice (second 8'h6E) while a frame is in flight -> no config write until tx_idle = 1; then a single write = 40 with out_port = 16'h006E.
